ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request,
// clocks out one command byte with odd parity and captures the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t state, next;

  logic          clk_s1, clk_s2, clk_s3;
  logic          data_s1, data_s2;
  logic [CW-1:0] cnt;
  logic [3:0]    edge_cnt;
  logic [7:0]    wbyte;
  logic          parity;
  logic          dreg;
  logic          ack_smp;
  logic          fall;
  logic          in_frame;
  logic          timeout;
  logic          lines_idle;

  assign fall       = clk_s3 & ~clk_s2;
  assign in_frame   = (state == SEND) || (state == ACK);
  assign timeout    = in_frame && !fall && (cnt == TO_LIMIT);
  assign lines_idle = clk_s2 & data_s2;

  // State register
  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= next;
  end

  // Next-state decode; an edge beats a simultaneous timeout
  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (wr) next = INHIBIT;
      INHIBIT:   if (cnt == INH_LAST) next = REQ;
      REQ:       next = SEND;
      SEND: begin
        if (fall && edge_cnt == 4'd9) next = ACK;
        else if (timeout)             next = IDLE;
      end
      ACK: begin
        if (fall)         next = WAIT_IDLE;
        else if (timeout) next = IDLE;
      end
      WAIT_IDLE: if (lines_idle) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // Synchronizers, counters, bit shifting and ACK capture
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_s3   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      cnt      <= '0;
      edge_cnt <= '0;
      wbyte    <= '0;
      parity   <= 1'b0;
      dreg     <= 1'b0;
      ack_smp  <= 1'b0;
      ack_ok   <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
      unique case (state)
        IDLE: begin
          if (wr) begin
            wbyte    <= wdata;
            parity   <= ~^wdata;
            cnt      <= '0;
            edge_cnt <= '0;
          end
        end
        INHIBIT: begin
          cnt  <= cnt + CW'(1);
          dreg <= 1'b1;
        end
        REQ: begin
          cnt      <= '0;
          edge_cnt <= '0;
          dreg     <= 1'b1;
        end
        SEND: begin
          if (fall) begin
            cnt      <= '0;
            edge_cnt <= edge_cnt + 4'd1;
            if (edge_cnt < 4'd8)
              dreg <= ~wbyte[edge_cnt[2:0]];
            else if (edge_cnt == 4'd8)
              dreg <= ~parity;
            else
              dreg <= 1'b0;
          end else if (!timeout) begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          if (fall) begin
            ack_smp  <= ~data_s2;
            edge_cnt <= 4'd11;
          end else if (!timeout) begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: if (lines_idle) ack_ok <= ack_smp;
        default: ;
      endcase
    end
  end

  // Line drivers and status outputs; reset releases lines at once
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    busy        = (state != IDLE);
    if (clrn) begin
      ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
      ps2_data_oe = (state == REQ) || (in_frame && dreg);
      done        = (state == WAIT_IDLE) && lines_idle;
      err         = timeout;
    end
  end

endmodule
